// File: rtl/gba_keypad_pkg.sv
// gba_keypad_pkg: GBA/SNES key index maps and KEYCNT field positions for the keypad unit.
// Rev 1.0
`default_nettype none

package gba_keypad_pkg;

   localparam int NUM_KEYS = 10;

   // GBA KEYINPUT bit positions
   localparam int KEY_A      = 0;
   localparam int KEY_B      = 1;
   localparam int KEY_SELECT = 2;
   localparam int KEY_START  = 3;
   localparam int KEY_RIGHT  = 4;
   localparam int KEY_LEFT   = 5;
   localparam int KEY_UP     = 6;
   localparam int KEY_DOWN   = 7;
   localparam int KEY_R      = 8;
   localparam int KEY_L      = 9;

   // SNES controller shift-register bit positions
   localparam int SNES_B      = 0;
   localparam int SNES_Y      = 1;
   localparam int SNES_SELECT = 2;
   localparam int SNES_START  = 3;
   localparam int SNES_UP     = 4;
   localparam int SNES_DOWN   = 5;
   localparam int SNES_LEFT   = 6;
   localparam int SNES_RIGHT  = 7;
   localparam int SNES_A      = 8;
   localparam int SNES_X      = 9;
   localparam int SNES_L      = 10;
   localparam int SNES_R      = 11;

   localparam int KEYCNT_IRQ_EN = 14;
   localparam int KEYCNT_AND    = 15;

   localparam logic [NUM_KEYS-1:0] KEYS_RELEASED = '1;

   function automatic int snes_bit_for_key(input int key);
      case (key)
         KEY_A:      return SNES_A;
         KEY_B:      return SNES_B;
         KEY_SELECT: return SNES_SELECT;
         KEY_START:  return SNES_START;
         KEY_RIGHT:  return SNES_RIGHT;
         KEY_LEFT:   return SNES_LEFT;
         KEY_UP:     return SNES_UP;
         KEY_DOWN:   return SNES_DOWN;
         KEY_R:      return SNES_R;
         KEY_L:      return SNES_L;
         default:    return SNES_A;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// key_debounce: one key's synchroniser, stability counter and debounced state flop.
// Rev 1.0
`default_nettype none

module key_debounce
   import gba_keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 84000,
   parameter int CNT_W           = 17,
   parameter int SYNC_STAGES     = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic [CNT_W-1:0]       count;

   // Released (1) is the safe idle level, so the chain powers up released.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count  <= '0;
         stable <= 1'b1;
      end else if (synced == stable) begin
         count <= '0;
      end else if (count == CNT_LAST) begin
         count  <= '0;
         stable <= synced;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/keypad_unit.sv
// keypad_unit: SNES buttons -> debounced GBA KEYINPUT plus KEYCNT keypad interrupt pulse.
// Rev 1.0
`default_nettype none

module keypad_unit
   import gba_keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 84000,
   parameter int CNT_W           = 17,
   parameter int SYNC_STAGES     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] buttons,
   input  logic [15:0] keycnt,
   output logic [15:0] key_input,
   output logic        keypad_irq
);

   logic [NUM_KEYS-1:0] remapped;
   logic [NUM_KEYS-1:0] stable;
   logic [NUM_KEYS-1:0] select;
   logic [NUM_KEYS-1:0] pressed;
   logic                cond;
   logic                level;
   logic                cond_prev;
   logic                unused_bits;

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      assign remapped[k] = buttons[snes_bit_for_key(k)];

      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_debounce (
         .clock  (clock),
         .reset  (reset),
         .raw    (remapped[k]),
         .stable (stable[k])
      );
   end

   // SNES X/Y, the padding nibble and the KEYCNT gap have no GBA meaning.
   assign unused_bits = ^{buttons[15:12], buttons[SNES_X], buttons[SNES_Y], keycnt[13:10]};

   assign key_input = {{(16-NUM_KEYS){1'b0}}, stable};
   assign select    = keycnt[NUM_KEYS-1:0];

   always_comb begin
      pressed = ~stable & select;
      cond    = 1'b0;
      if (keycnt[KEYCNT_AND]) begin
         cond = (pressed == select) && (select != '0);
      end else begin
         cond = |pressed;
      end
   end

   assign level = cond & keycnt[KEYCNT_IRQ_EN];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cond_prev  <= 1'b0;
         keypad_irq <= 1'b0;
      end else begin
         cond_prev  <= level;
         keypad_irq <= level & ~cond_prev;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_keypad_unit.sv
// tb_keypad_unit: directed and randomized checks of keypad_unit against a behavioural model.
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_unit;

   localparam int DEB  = 4;
   localparam int SYNC = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] buttons = 16'hFFFF;
   logic [15:0] keycnt = 16'h0000;
   logic [15:0] key_input;
   logic        keypad_irq;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   keypad_unit #(
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (17),
      .SYNC_STAGES     (SYNC)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .buttons    (buttons),
      .keycnt     (keycnt),
      .key_input  (key_input),
      .keypad_irq (keypad_irq)
   );

   // Reference model: GBA key k reads SNES bit snes_of[k]; a key's state flips once
   // its delayed sample has disagreed with it for DEB consecutive cycles.
   int         snes_of [10] = '{8, 0, 2, 3, 7, 6, 4, 5, 11, 10};
   logic [9:0] m_stable;
   logic       m_prev;
   logic       m_irq;
   logic [9:0] raw_hist[$];
   logic [9:0] sync_hist[$];

   function automatic logic [9:0] remap(input logic [15:0] b);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[i] = b[snes_of[i]];
      return r;
   endfunction

   function automatic logic cond_of(input logic [9:0] st, input logic [15:0] kc);
      logic [9:0] sel;
      logic [9:0] held;
      sel  = kc[9:0];
      held = ~st & sel;
      if (sel == 10'd0) return 1'b0;
      if (kc[15]) return held == sel;
      return held != 10'd0;
   endfunction

   always @(posedge clock or posedge reset) begin
      logic       lvl;
      logic [9:0] synced;
      logic       all_diff;
      if (reset) begin
         m_stable = '1;
         m_prev   = 1'b0;
         m_irq    = 1'b0;
         raw_hist.delete();
         sync_hist.delete();
         repeat (SYNC) raw_hist.push_back(10'h3FF);
         repeat (DEB) sync_hist.push_back(10'h3FF);
      end else begin
         lvl    = cond_of(m_stable, keycnt) & keycnt[14];
         m_irq  = lvl & ~m_prev;
         m_prev = lvl;
         synced = raw_hist[0];
         raw_hist.pop_front();
         raw_hist.push_back(remap(buttons));
         sync_hist.pop_front();
         sync_hist.push_back(synced);
         for (int k = 0; k < 10; k++) begin
            all_diff = 1'b1;
            foreach (sync_hist[j]) if (sync_hist[j][k] == m_stable[k]) all_diff = 1'b0;
            if (all_diff) m_stable[k] = ~m_stable[k];
         end
      end
   end

   task automatic test_reset();
      logic [15:0] want;
      reset = 1'b1;
      buttons = 16'h0000;
      keycnt = 16'h0000;
      repeat (3) @(negedge clock);
      total++;
      if (key_input !== 16'h03FF) begin
         bad++;
         $display("FAIL reset_key: got %h want 03ff", key_input);
      end
      total++;
      if (keypad_irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_irq: got %b want 0", keypad_irq);
      end
      reset = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clock);
         want = (i >= SYNC + DEB) ? 16'h0000 : 16'h03FF;
         total++;
         if (key_input !== want || keypad_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_release cycle %0d: got %h/%b want %h/0", i, key_input, keypad_irq, want);
         end
      end
   endtask

   task automatic test_debounce();
      logic [15:0] want;
      buttons = 16'hFFFF;
      repeat (9) begin
         @(negedge clock);
         total++;
         if (key_input !== {6'b0, m_stable} || keypad_irq !== m_irq) begin
            bad++;
            $display("FAIL debounce_settle: got %h/%b want %h/%b", key_input, keypad_irq, {6'b0, m_stable}, m_irq);
         end
      end
      buttons = 16'hFEFF;
      repeat (DEB - 1) @(negedge clock);
      buttons = 16'hFFFF;
      repeat (10) begin
         @(negedge clock);
         total++;
         if (key_input !== 16'h03FF) begin
            bad++;
            $display("FAIL debounce_glitch: got %h want 03ff", key_input);
         end
      end
      buttons = 16'hFEFF;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clock);
         want = (i >= SYNC + DEB) ? 16'h03FE : 16'h03FF;
         total++;
         if (key_input !== want) begin
            bad++;
            $display("FAIL debounce_latency cycle %0d: got %h want %h", i, key_input, want);
         end
      end
   endtask

   task automatic test_remap();
      buttons = 16'hFFEF;
      repeat (10) @(negedge clock);
      total++;
      if (key_input !== 16'h03BF) begin
         bad++;
         $display("FAIL remap_up: got %h want 03bf", key_input);
      end
      buttons = 16'hFDEF;
      repeat (10) @(negedge clock);
      total++;
      if (key_input !== 16'h03BF) begin
         bad++;
         $display("FAIL remap_x_ignored: got %h want 03bf", key_input);
      end
      for (int t = 0; t < 8; t++) begin
         buttons = 16'($urandom);
         repeat (9) begin
            @(negedge clock);
            total++;
            if (key_input !== {6'b0, m_stable} || keypad_irq !== m_irq) begin
               bad++;
               $display("FAIL remap_random: buttons=%h got %h/%b want %h/%b", buttons, key_input, keypad_irq, {6'b0, m_stable}, m_irq);
            end
         end
      end
   endtask

   task automatic test_or_irq();
      int n;
      int pulses;
      keycnt = 16'h0000;
      buttons = 16'hFFFF;
      repeat (10) @(negedge clock);
      keycnt = 16'h4003;
      repeat (3) @(negedge clock);
      buttons = 16'hFFFE;
      n = 0;
      while (key_input[1] !== 1'b0 && n < 20) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL or_wait_b: key_input=%h never showed B pressed", key_input);
      end
      total++;
      if (keypad_irq !== 1'b0) begin
         bad++;
         $display("FAIL or_irq_early: got %b want 0", keypad_irq);
      end
      @(negedge clock);
      total++;
      if (keypad_irq !== 1'b1) begin
         bad++;
         $display("FAIL or_irq_pulse: got %b want 1", keypad_irq);
      end
      pulses = 0;
      repeat (100) begin
         @(negedge clock);
         if (keypad_irq === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL or_no_repeat: got %0d pulses want 0", pulses);
      end
      buttons = 16'hFFFF;
      repeat (10) @(negedge clock);
      buttons = 16'hFFFE;
      pulses = 0;
      repeat (12) begin
         @(negedge clock);
         if (keypad_irq === 1'b1) pulses++;
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL or_repress: got %0d pulses want 1", pulses);
      end
   endtask

   task automatic test_and_irq();
      int pulses;
      keycnt = 16'hC00C;
      buttons = 16'hFFFF;
      repeat (10) @(negedge clock);
      buttons = 16'hFFF7;
      pulses = 0;
      repeat (12) begin
         @(negedge clock);
         if (keypad_irq === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL and_partial: got %0d pulses want 0", pulses);
      end
      buttons = 16'hFFF3;
      pulses = 0;
      repeat (12) begin
         @(negedge clock);
         if (keypad_irq === 1'b1) pulses++;
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL and_full: got %0d pulses want 1", pulses);
      end
      keycnt = 16'hC000;
      buttons = 16'h0000;
      pulses = 0;
      repeat (12) begin
         @(negedge clock);
         if (keypad_irq === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL and_zero_mask: got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_enable();
      int pulses;
      int want [5] = '{0, 1, 1, 1, 0};
      logic [15:0] pre [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h4002, 16'h4001};
      logic [15:0] post [5] = '{16'h0001, 16'h4001, 16'h4001, 16'h4001, 16'hC001};
      buttons = 16'hFEFF;
      for (int s = 0; s < 5; s++) begin
         keycnt = pre[s];
         repeat (12) @(negedge clock);
         keycnt = post[s];
         pulses = 0;
         repeat (10) begin
            @(negedge clock);
            if (keypad_irq === 1'b1) pulses++;
         end
         total++;
         if (pulses != want[s]) begin
            bad++;
            $display("FAIL enable_step%0d keycnt %h->%h: got %0d pulses want %0d", s, pre[s], post[s], pulses, want[s]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int pulses;
      buttons = 16'hFEFE;
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      total++;
      if (key_input !== 16'h03FF || keypad_irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_debounce: got %h/%b want 03ff/0", key_input, keypad_irq);
      end
      @(negedge clock);
      reset = 1'b0;
      buttons = 16'hFFFF;
      pulses = 0;
      repeat (12) begin
         @(negedge clock);
         if (keypad_irq === 1'b1) pulses++;
         total++;
         if (key_input !== 16'h03FF) begin
            bad++;
            $display("FAIL reset_pending_lost: got %h want 03ff", key_input);
         end
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL reset_no_pulse: got %0d pulses want 0", pulses);
      end
      keycnt = 16'h4001;
      buttons = 16'hFEFF;
      n = 0;
      while (keypad_irq !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL reset_wait_pulse: keypad_irq never rose");
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if (keypad_irq !== 1'b0 || key_input !== 16'h03FF) begin
         bad++;
         $display("FAIL reset_mid_pulse: got %h/%b want 03ff/0", key_input, keypad_irq);
      end
      @(negedge clock);
      reset = 1'b0;
      buttons = 16'hFFFF;
      pulses = 0;
      repeat (12) begin
         @(negedge clock);
         if (keypad_irq === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL reset_after_pulse: got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 120; t++) begin
         buttons = 16'($urandom);
         if ($urandom_range(0, 3) == 0) keycnt = 16'($urandom);
         if ($urandom_range(0, 19) == 0) reset = 1'b1;
         repeat ($urandom_range(1, 9)) begin
            @(negedge clock);
            reset = 1'b0;
            total++;
            if (key_input !== {6'b0, m_stable} || keypad_irq !== m_irq) begin
               bad++;
               $display("FAIL random t=%0d buttons=%h keycnt=%h: got %h/%b want %h/%b", t, buttons, keycnt, key_input, keypad_irq, {6'b0, m_stable}, m_irq);
            end
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_debounce();
      test_remap();
      test_or_irq();
      test_and_irq();
      test_enable();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/keypad_unit.md
Name: keypad_unit

Overview:
Sits between the SNES controller interface and the interrupt controller / MMIO block. Takes the raw active-low 16-bit SNES button word and synchronises and debounces it. Remaps it to the GBA KEYINPUT layout, evaluates the KEYCNT interrupt condition, and emits a one-cycle keypad interrupt request. Feeds KEYINPUT to memory-mapped IO and `keypad` to interrupt_controller (replacing the constant 0).

Parameters:
DEBOUNCE_CYCLES, 84000, consecutive stable cycles required before a key change is accepted (~5 ms at 16.78 MHz); legal range 1..2^CNT_W-1
CNT_W, 17, debounce counter width
SYNC_STAGES, 2, synchroniser depth (>=2)

Ports:
clock  input  1  system clock (gba_clk)
reset  input  1  asynchronous, active-high reset
buttons  input  16  raw SNES buttons, active-low; [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R; [15:12] ignored
keycnt  input  16  KEYCNT register: [9:0] key select, [14] IRQ enable, [15] condition (0=OR, 1=AND)
key_input  output  16  KEYINPUT value, active-low; [9:0] keys, [15:10] = 0
keypad_irq  output  1  one-cycle interrupt request pulse

Behaviour:
- Reset values: sync flops all 1; debounced state all 1 (released); counters 0; cond_prev 0; key_input = 16'h03FF; keypad_irq = 0.
- Remap before synchronising to 10 GBA keys:
  - GBA[0] A = SNES[8]
  - GBA[1] B = SNES[0]
  - GBA[2] Select = SNES[2]
  - GBA[3] Start = SNES[3]
  - GBA[4] Right = SNES[7]
  - GBA[5] Left = SNES[6]
  - GBA[6] Up = SNES[4]
  - GBA[7] Down = SNES[5]
  - GBA[8] R = SNES[11]
  - GBA[9] L = SNES[10]
  - SNES X/Y unused.
- Synchroniser: SYNC_STAGES flops per key.
- Debounce, per key, independently:
  - If the synced value equals the stable value, the counter clears to 0.
  - Otherwise the counter increments. When the counter == DEBOUNCE_CYCLES-1 and the value still differs, stable <= synced and the counter <= 0 in the same cycle.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the count; the stable value is untouched.
  - Latency from an input edge to a key_input change: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - The counter never wraps; saturation is impossible given the range rule.
- key_input = {6'b0, stable[9:0]}, registered.
- Condition (combinational on registered state), with pressed = ~stable & keycnt[9:0]:
  - OR mode (keycnt[15]=0): cond = |pressed.
  - AND mode (keycnt[15]=1): cond = (pressed == keycnt[9:0]) && (keycnt[9:0] != 0).
  - A zero select mask never matches in either mode.
- IRQ: level = cond & keycnt[14]; cond_prev <= level each cycle; keypad_irq (registered) = level & ~cond_prev.
  - One pulse per rising edge of level.
  - Holding keys gives no repeat.
  - Enabling keycnt[14] while the condition already holds fires exactly one pulse.
  - Disabling and re-enabling while held fires again.
  - Changing keycnt mask or mode so the condition becomes newly true fires one pulse.
- Simultaneous key changes debounce independently; a condition met by several keys resolving in the same cycle gives one pulse.
- Asynchronous reset mid-debounce or mid-pulse returns all state to reset values immediately; no pulse after reset deassertion unless a new rising edge of level occurs.
- buttons[15:12] have no effect on any output.

Decomposition:
- Package gba_keypad_pkg:
  - GBA key index constants (KEY_A..KEY_L, NUM_KEYS=10)
  - SNES bit index constants
  - KEYCNT field positions (KEYCNT_IRQ_EN=14, KEYCNT_AND=15)
- Sub-module key_debounce: one key's synchroniser, counter and stable flop, parameterised by DEBOUNCE_CYCLES, CNT_W, SYNC_STAGES; instantiated NUM_KEYS times via generate.
- Top keypad_unit holds the remap, the condition logic and the IRQ edge detector.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4.)
- Reset: hold reset with buttons=16'h0000 -> key_input=16'h03FF, keypad_irq=0; release reset -> key_input=16'h0000 (all pressed) after 2+4 cycles, no IRQ with keycnt=0.
- Debounce: drive SNES A (bit 8) low for 3 cycles then high -> key_input stays 16'h03FF. Hold low for 6 cycles -> key_input=16'h03FE exactly 6 cycles after the edge.
- Remap: press SNES Up only (buttons=16'hFFEF) -> key_input=16'h03BF; press SNES X -> key_input unchanged.
- OR IRQ: keycnt=16'h4003 (enable, OR, A|B), press B -> single keypad_irq pulse on the cycle after key_input[1] falls. Keep B held 100 cycles -> no further pulse. Release and press again -> second pulse.
- AND IRQ: keycnt=16'hC00C (Start+Select), press Start only -> no pulse; then press Select -> one pulse. keycnt=16'hC000 with all keys pressed -> no pulse.
- Enable and reset corner: hold A with keycnt=16'h0001, then write 16'h4001 -> one pulse. Assert reset mid-debounce -> key_input=16'h03FF immediately and the pending change is lost.
